game_flow_controller: RTL and testbench

Frame-rate sequencer for the obstacle datapath in the colour mapper. Owns the game state (title, play, death, level done), drives the screen enable, and generates the scrolling obstacle base X coordinate that the colour mapper offsets into the individual spike and platform positions. It consumes the colour mapper's `hit` flag and the keyboard keycode, and sits between the USB keycode path, the VGA frame timing and `color_mapper`.

---
 rtl/game_flow_controller.sv | 131 +++++++++++++
 tb/tb_game_flow_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - game state sequencer and scrolling obstacle base X generator
module game_flow_controller #(
    parameter int          START_X      = 640,
    parameter int          GROUP_SPAN   = 600,
    parameter int          SCROLL_STEP  = 4,
    parameter int          DEATH_FRAMES = 30,
    parameter int          LEVEL_LOOPS  = 3,
    parameter logic [7:0]  START_KEY    = 8'h2C
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic [7:0]  keycode,
    output logic [10:0] obstacle_x,
    output logic        screen,
    output logic        run_active,
    output logic        level_done,
    output logic [7:0]  attempt_cnt,
    output logic [3:0]  loop_cnt
);

    // At least 3 bits so the blink tap death_cnt[2] always exists.
    localparam int DW = ($clog2(DEATH_FRAMES) < 3) ? 3 : $clog2(DEATH_FRAMES);
    localparam logic [10:0]        X_START    = 11'(START_X);
    localparam logic signed [11:0] X_MIN      = 12'(-GROUP_SPAN);
    localparam logic signed [11:0] X_STEP     = 12'(SCROLL_STEP);
    localparam logic [DW-1:0]      DEATH_LAST = DW'(DEATH_FRAMES - 1);
    localparam logic [3:0]         LOOPS      = 4'(LEVEL_LOOPS);

    typedef enum logic [1:0] {TITLE, PLAY, DYING, DONE} state_t;

    state_t                state;
    logic [7:0]            prev_key;
    logic [DW-1:0]         death_cnt;
    logic                  start_edge;
    logic signed [11:0]    x_ext;
    logic signed [11:0]    x_dec;
    logic                  wrap;
    logic [7:0]            attempt_inc;
    logic [3:0]            loop_inc;
    logic [DW-1:0]         death_dec;

    assign start_edge  = (keycode == START_KEY) && (prev_key != START_KEY);
    assign x_ext       = signed'({obstacle_x[10], obstacle_x});
    assign x_dec       = x_ext - X_STEP;
    assign wrap        = (x_dec < X_MIN);
    assign attempt_inc = (attempt_cnt == 8'hFF) ? attempt_cnt : attempt_cnt + 8'd1;
    assign loop_inc    = loop_cnt + 4'd1;
    assign death_dec   = death_cnt - DW'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= TITLE;
            prev_key    <= 8'd0;
            death_cnt   <= '0;
            obstacle_x  <= X_START;
            screen      <= 1'b0;
            run_active  <= 1'b0;
            level_done  <= 1'b0;
            attempt_cnt <= 8'd0;
            loop_cnt    <= 4'd0;
        end else begin
            prev_key <= keycode;
            case (state)
                TITLE: begin
                    if (start_edge) begin
                        state       <= PLAY;
                        obstacle_x  <= X_START;
                        loop_cnt    <= 4'd0;
                        attempt_cnt <= attempt_inc;
                        screen      <= 1'b1;
                        run_active  <= 1'b1;
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        // A hit takes priority over a wrap on the same frame.
                        if (hit) begin
                            state      <= DYING;
                            death_cnt  <= DEATH_LAST;
                            screen     <= ~DEATH_LAST[2];
                            run_active <= 1'b0;
                        end else if (wrap) begin
                            obstacle_x <= X_START;
                            loop_cnt   <= loop_inc;
                            if (loop_inc == LOOPS) begin
                                state      <= DONE;
                                run_active <= 1'b0;
                                level_done <= 1'b1;
                            end
                        end else begin
                            obstacle_x <= x_dec[10:0];
                        end
                    end
                end
                DYING: begin
                    if (frame_tick) begin
                        if (death_cnt == '0) begin
                            state       <= PLAY;
                            obstacle_x  <= X_START;
                            loop_cnt    <= 4'd0;
                            attempt_cnt <= attempt_inc;
                            screen      <= 1'b1;
                            run_active  <= 1'b1;
                        end else begin
                            death_cnt <= death_dec;
                            screen    <= ~death_dec[2];
                        end
                    end
                end
                DONE: begin
                    if (start_edge) begin
                        state      <= TITLE;
                        obstacle_x <= X_START;
                        screen     <= 1'b0;
                        level_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= TITLE;
                    obstacle_x <= X_START;
                    screen     <= 1'b0;
                    run_active <= 1'b0;
                    level_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// tb/tb_game_flow_controller.sv - scoreboard bench for game_flow_controller
module tb_game_flow_controller;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic        hit = 1'b0;
    logic [7:0]  keycode = 8'd0;
    logic [10:0] obstacle_x;
    logic        screen;
    logic        run_active;
    logic        level_done;
    logic [7:0]  attempt_cnt;
    logic [3:0]  loop_cnt;

    logic        obs = 1'b0;
    logic [25:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad = 0;

    game_flow_controller #(
        .START_X(640), .GROUP_SPAN(600), .SCROLL_STEP(4),
        .DEATH_FRAMES(30), .LEVEL_LOOPS(2), .START_KEY(8'h2C)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .hit(hit),
        .keycode(keycode), .obstacle_x(obstacle_x), .screen(screen),
        .run_active(run_active), .level_done(level_done),
        .attempt_cnt(attempt_cnt), .loop_cnt(loop_cnt)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    // Monitor: pops one expectation per observation strobe.
    always @(negedge Clk) begin
        if (obs) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: actual=empty queue required=entry");
            end else begin
                logic [25:0] e;
                logic [25:0] a;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = {obstacle_x, screen, run_active, level_done, attempt_cnt, loop_cnt};
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: actual x=%0d scr=%b run=%b done=%b att=%0d loop=%0d required x=%0d scr=%b run=%b done=%b att=%0d loop=%0d",
                             n, $signed(a[25:15]), a[14], a[13], a[12], a[11:4], a[3:0],
                             $signed(e[25:15]), e[14], e[13], e[12], e[11:4], e[3:0]);
                end
            end
        end
    end

    task automatic drive(input logic [7:0] k, input logic t, input logic h);
        keycode = k;
        frame_tick = t;
        hit = h;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
        hit = 1'b0;
    endtask

    task automatic ticks(input int n, input logic h);
        repeat (n) drive(keycode, 1'b1, h);
    endtask

    task automatic expect_state(input string nm, input int x, input logic s, input logic r,
                                input logic d, input int att, input int lp);
        exp_q.push_back({11'(x), s, r, d, 8'(att), 4'(lp)});
        name_q.push_back(nm);
        obs = 1'b1;
        @(negedge Clk);
        #1;
        obs = 1'b0;
    endtask

    initial begin
        expect_state("reset", 640, 0, 0, 0, 0, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Held start key: exactly one transition.
        drive(8'h2C, 0, 0);
        expect_state("start", 640, 1, 1, 0, 1, 0);
        repeat (9) drive(8'h2C, 0, 0);
        expect_state("held_key", 640, 1, 1, 0, 1, 0);

        ticks(10, 0);
        expect_state("scroll10", 600, 1, 1, 0, 1, 0);
        drive(8'h2C, 0, 1);
        drive(8'h00, 0, 1);
        expect_state("hit_no_tick", 600, 1, 1, 0, 1, 0);

        ticks(299, 0);
        expect_state("x_m596", -596, 1, 1, 0, 1, 0);
        ticks(1, 0);
        expect_state("x_m600", -600, 1, 1, 0, 1, 0);
        ticks(1, 0);
        expect_state("wrap1", 640, 1, 1, 0, 1, 1);

        ticks(5, 0);
        expect_state("x620", 620, 1, 1, 0, 1, 1);
        ticks(1, 1);
        expect_state("hit_dying", 620, 0, 0, 0, 1, 1);
        ticks(1, 1);
        expect_state("dying_d28", 620, 0, 0, 0, 1, 1);
        ticks(2, 0);
        expect_state("dying_d26", 620, 1, 0, 0, 1, 1);
        drive(8'h2C, 0, 0);
        drive(8'h00, 0, 0);
        ticks(26, 0);
        expect_state("dying_d0", 620, 1, 0, 0, 1, 1);
        ticks(1, 0);
        expect_state("respawn", 640, 1, 1, 0, 2, 0);

        ticks(311, 0);
        expect_state("run2_wrap", 640, 1, 1, 0, 2, 1);
        ticks(310, 0);
        expect_state("run2_m600", -600, 1, 1, 0, 2, 1);
        ticks(1, 1);
        expect_state("hit_beats_wrap", -600, 0, 0, 0, 2, 1);
        ticks(30, 0);
        expect_state("respawn2", 640, 1, 1, 0, 3, 0);

        ticks(311, 0);
        expect_state("run3_wrap", 640, 1, 1, 0, 3, 1);
        ticks(311, 0);
        expect_state("done", 640, 1, 0, 1, 3, 2);

        drive(8'h2C, 1, 0);
        expect_state("done_to_title", 640, 0, 0, 0, 3, 2);
        drive(8'h00, 1, 0);
        expect_state("title_tick", 640, 0, 0, 0, 3, 2);
        drive(8'h2C, 0, 0);
        expect_state("restart", 640, 1, 1, 0, 4, 0);

        drive(8'h00, 1, 1);
        ticks(17, 0);
        expect_state("dying_d12", 640, 0, 0, 0, 4, 0);

        // Asynchronous reset in the middle of a cycle, with a tick present.
        #2;
        Reset = 1'b1;
        frame_tick = 1'b1;
        hit = 1'b1;
        expect_state("mid_reset", 640, 0, 0, 0, 0, 0);
        frame_tick = 1'b0;
        hit = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        drive(8'h2C, 0, 0);
        expect_state("post_reset_start", 640, 1, 1, 0, 1, 0);

        @(negedge Clk);
        @(negedge Clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: actual=%0d left required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
